fft_col_sequencer: RTL and testbench
====================================

Name: fft_col_sequencer

Overview:
- Sequences the 32-point column FFT stage (fftc1) across a frame of NUM_COLS columns.
- Per column: collects N complex samples from a serial stream into a parallel input buffer, drives the fftc1 bus, holds fftc1 out of reset for LATENCY cycles, captures the parallel result, then streams it out serially.
- Sits between the sample memory/stream source and the next FFT stage; fftc1 is instantiated alongside it, not inside it.

Parameters:
- N, 32, points per column (samples per fftc1 transform)
- W, 64, complex sample width: [W-1:W/2] real, [W/2-1:0] imag
- LATENCY, 8, clk cycles fftc1 needs after reset release before its output is valid
- NUM_COLS, 32, columns per frame

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- in_data  in  W  serial input sample
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts in_data this cycle
- fft_in  out  N*W  parallel bus to fftc1; slot k at [k*W+W-1:k*W]
- fft_rst  out  1  active-high reset to fftc1
- fft_out  in  N*W  parallel result from fftc1, same slot packing
- out_data  out  W  serial output sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- col_idx  out  5  current column, 0..NUM_COLS-1
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse after last sample of last column is accepted

Behaviour:
- Reset (reset=0, async): state=IDLE, in_ready=0, out_valid=0, out_data=0, fft_in=0, fft_rst=1, col_idx=0, busy=0, done=0. Both counters and the capture buffer are cleared. A reset asserted mid-frame aborts the frame; no partial output follows.
- States: IDLE, LOAD, RUN, UNLOAD. All outputs are registered except in_ready and out_valid, which decode the state.
- IDLE: on start=1 -> LOAD, col_idx=0, load_cnt=0. start is ignored in all other states.
- LOAD: in_ready=1. A sample is accepted when in_valid & in_ready; it is written to fft_in slot load_cnt and load_cnt increments. When slot N-1 is accepted -> RUN, wait_cnt=0. fft_rst stays 1 throughout LOAD.
- RUN: in_ready=0, fft_rst=0, fft_in held stable. wait_cnt increments each cycle. At wait_cnt==LATENCY-1, fft_out is captured into the output buffer on that edge -> UNLOAD, unload_cnt=0, fft_rst=1. RUN lasts exactly LATENCY cycles.
- UNLOAD: out_valid=1, out_data=buffer slot unload_cnt. On out_valid & out_ready, unload_cnt increments. When slot N-1 is accepted:
  - If col_idx==NUM_COLS-1: done=1 for one cycle -> IDLE, col_idx=0.
  - Otherwise: col_idx++, load_cnt=0 -> LOAD.
- Backpressure: in_valid=0 or out_ready=0 stalls the respective counter indefinitely with no data loss. out_data is stable while out_valid & !out_ready.
- No overlap: the next column's LOAD starts only after UNLOAD completes. in_ready and out_valid are never high together.
- Counters: load_cnt and unload_cnt are log2(N) bits and never wrap mid-column. wait_cnt is sized for LATENCY.
- Data is passed through bit-exact; the sequencer performs no arithmetic on samples.

Test Plan:
- Single column (NUM_COLS=1): start, then feed 32 samples {real=k, imag=0}, k=0..31, with in_valid held high. Required: in_ready high for exactly 32 cycles; fft_rst low for exactly 8 cycles; 32 out_valid beats equal to the fftc1 reference output (c1_output golden file); done pulses once; busy drops the next cycle.
- Input stall: toggle in_valid every other cycle. Required: fft_in slot k still equals sample k; RUN entered only after the 32nd accept.
- Output backpressure: hold out_ready=0 for 5 cycles at unload_cnt=7. Required: out_data stays equal to slot 7; no beat is skipped or duplicated.
- Multi-column (NUM_COLS=4): 128 input samples. Required: col_idx steps 0,1,2,3; 4 RUN windows of 8 cycles; done asserted exactly once, after beat 127.
- Reset mid-RUN: drive reset=0 at wait_cnt=3. Required: immediately IDLE, fft_rst=1, out_valid=0, col_idx=0; a following start runs a clean frame.
- start while busy: pulse start during LOAD. Required: no effect on counters or col_idx.

Source files
------------

// File: rtl/fft_col_sequencer.sv
// -----------------------------------------------------------------------------
// fft_col_sequencer
//
// Drives the 32-point column FFT stage (fftc1) across a frame of NUM_COLS
// columns. Per column it gathers N serial samples into the parallel fftc1
// input bus, releases fftc1 from reset for LATENCY cycles, captures the
// parallel result and streams it back out serially. Columns never overlap:
// the next column starts loading only after the previous one is unloaded.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (aborts any frame)
//   start      in   begin a frame (only honoured in IDLE)
//   in_data    in   W   serial input sample {real, imag}
//   in_valid   in   in_data valid
//   in_ready   out  sequencer accepts in_data (LOAD only)
//   fft_in     out  N*W parallel bus to fftc1, slot k at [k*W +: W]
//   fft_rst    out  active-high reset to fftc1, low only while in RUN
//   fft_out    in   N*W parallel result from fftc1, same packing
//   out_data   out  W   serial output sample
//   out_valid  out  out_data valid (UNLOAD only)
//   out_ready  in   downstream accepts out_data
//   col_idx    out  5   current column
//   busy       out  high in any state other than IDLE
//   done       out  one-cycle pulse after the last beat of the last column
//   dbg_state  out  2   current FSM state (IDLE=0, LOAD=1, RUN=2, UNLOAD=3)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits for ready, and a source holding valid keeps
// its data stable until the transfer.
// -----------------------------------------------------------------------------
module fft_col_sequencer #(
    parameter int N        = 32,
    parameter int W        = 64,
    parameter int LATENCY  = 8,
    parameter int NUM_COLS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N*W-1:0]   fft_in,
    output logic             fft_rst,
    input  logic [N*W-1:0]   fft_out,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       col_idx,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    load_cnt_q, load_cnt_d;
    logic [CW-1:0]    unload_cnt_q, unload_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [4:0]       col_idx_q, col_idx_d;
    logic [N*W-1:0]   fft_in_q, fft_in_d;
    logic [N*W-1:0]   buf_q, buf_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             fft_rst_q, fft_rst_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [CW:0]      next_slot;

    // Slot presented after the current output beat is accepted; one bit
    // wider than the counter so it cannot alias on the last slot.
    assign next_slot = {1'b0, unload_cnt_q} + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            unload_cnt_q <= '0;
            wait_cnt_q   <= '0;
            col_idx_q    <= '0;
            fft_in_q     <= '0;
            buf_q        <= '0;
            out_data_q   <= '0;
            fft_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            unload_cnt_q <= unload_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            col_idx_q    <= col_idx_d;
            fft_in_q     <= fft_in_d;
            buf_q        <= buf_d;
            out_data_q   <= out_data_d;
            fft_rst_q    <= fft_rst_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        unload_cnt_d = unload_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        col_idx_d    = col_idx_q;
        fft_in_d     = fft_in_q;
        buf_d        = buf_q;
        out_data_d   = out_data_q;
        fft_rst_d    = fft_rst_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    col_idx_d  = '0;
                    load_cnt_d = '0;
                end
            end

            S_LOAD: begin
                if (in_valid) begin
                    fft_in_d[load_cnt_q*W +: W] = in_data;
                    if (load_cnt_q == CW'(N-1)) begin
                        // Last slot written: release fftc1 from reset.
                        state_d    = S_RUN;
                        wait_cnt_d = '0;
                        fft_rst_d  = 1'b0;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end

            S_RUN: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (wait_cnt_q == WW'(LATENCY-1)) begin
                    // fftc1 output is valid on this edge; capture it and
                    // preload the first output beat so out_data is registered.
                    buf_d        = fft_out;
                    out_data_d   = fft_out[W-1:0];
                    state_d      = S_UNLOAD;
                    unload_cnt_d = '0;
                    wait_cnt_d   = '0;
                    fft_rst_d    = 1'b1;
                end
            end

            S_UNLOAD: begin
                if (out_ready) begin
                    if (unload_cnt_q == CW'(N-1)) begin
                        out_data_d = '0;
                        if (col_idx_q == 5'(NUM_COLS-1)) begin
                            done_d    = 1'b1;
                            state_d   = S_IDLE;
                            col_idx_d = '0;
                        end else begin
                            col_idx_d  = col_idx_q + 5'd1;
                            load_cnt_d = '0;
                            state_d    = S_LOAD;
                        end
                    end else begin
                        unload_cnt_d = unload_cnt_q + 1'b1;
                        out_data_d   = buf_q[next_slot*W +: W];
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_UNLOAD);
    assign fft_in    = fft_in_q;
    assign fft_rst   = fft_rst_q;
    assign out_data  = out_data_q;
    assign col_idx   = col_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_col_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_col_sequencer
//
// Bench for fft_col_sequencer with a four-column frame. A stand-in for fftc1
// produces slot k = ~sample[N-1-k] only on the cycle that is exactly LATENCY
// edges after its reset release, and a poison pattern otherwise, so an early
// or late capture shows up as bad output data.
// -----------------------------------------------------------------------------
module tb_fft_col_sequencer;

    localparam int N        = 32;
    localparam int W        = 64;
    localparam int LATENCY  = 8;
    localparam int NUM_COLS = 4;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [W-1:0]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   fft_in;
    logic             fft_rst;
    logic [N*W-1:0]   fft_out;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       col_idx;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    fft_col_sequencer #(
        .N(N), .W(W), .LATENCY(LATENCY), .NUM_COLS(NUM_COLS)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fft_in(fft_in), .fft_rst(fft_rst), .fft_out(fft_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .col_idx(col_idx), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- fftc1 stand-in ----------------
    int fake_cnt = 0;

    always @(posedge clk) begin
        if (fft_rst) fake_cnt <= 0;
        else if (fake_cnt < 1000) fake_cnt <= fake_cnt + 1;
    end

    always_comb begin
        fft_out = '0;
        for (int k = 0; k < N; k++) begin
            if (fake_cnt == LATENCY-1)
                fft_out[k*W +: W] = ~fft_in[(N-1-k)*W +: W];
            else
                fft_out[k*W +: W] = 64'hBAD0_BAD0_BAD0_BAD0 ^ 64'(k);
        end
    end

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] col_buf[N];
    int           n_acc       = 0;
    int           col_beats   = 0;
    int           frame_beats = 0;
    int           model_col   = 0;
    bit           exp_done    = 0;
    int           rst_low_len = 0;
    bit           prev_stall  = 0;
    logic [W-1:0] prev_data   = '0;
    int           runs_cnt    = 0;
    int           done_cnt    = 0;
    int           ready_cycles = 0;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            n_acc       = 0;
            col_beats   = 0;
            frame_beats = 0;
            model_col   = 0;
            exp_done    = 0;
            rst_low_len = 0;
            prev_stall  = 0;
        end else begin
            check(!(in_ready && out_valid), "ready_valid_excl",
                  {in_ready, out_valid}, 0);
            check(done == exp_done, "done_pulse", done, exp_done);
            if (exp_done) begin
                check(busy == 1'b0, "busy_after_done", busy, 0);
                done_cnt++;
            end
            exp_done = 0;
            if (busy)
                check(col_idx == 5'(model_col), "col_idx", col_idx, model_col);
            if (prev_stall)
                check(out_data == prev_data, "hold_stable", out_data, prev_data);
            if (in_ready) ready_cycles++;

            if (in_valid && in_ready) begin
                if (n_acc < N) col_buf[n_acc] = in_data;
                n_acc++;
            end

            if (!fft_rst) begin
                if (rst_low_len == 0) begin
                    bit same;
                    same = 1;
                    check(n_acc == N, "run_after_last_accept", n_acc, N);
                    for (int k = 0; k < N; k++)
                        if (fft_in[k*W +: W] !== col_buf[k]) same = 0;
                    check(same, "fft_in_slots", same, 1);
                    for (int k = 0; k < N; k++)
                        exp_q.push_back(~col_buf[N-1-k]);
                    n_acc = 0;
                    runs_cnt++;
                end
                rst_low_len++;
            end else if (rst_low_len != 0) begin
                check(rst_low_len == LATENCY, "run_len", rst_low_len, LATENCY);
                rst_low_len = 0;
            end

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(0, "unexpected_beat", out_data, 0);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check(out_data == e, "out_data", out_data, e);
                end
                frame_beats++;
                col_beats++;
                if (col_beats == N) begin
                    col_beats = 0;
                    if (frame_beats == N*NUM_COLS) begin
                        exp_done    = 1;
                        frame_beats = 0;
                        model_col   = 0;
                    end else begin
                        model_col++;
                    end
                end
            end

            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W-1:0] gen(input int mode, input int k);
        if (mode == 0) return {32'(k % N), 32'd0};
        return {$urandom, $urandom};
    endfunction

    // in_mode: 0 ramp/always valid, 1 toggling valid, 2 random valid
    // out_mode: 0 always ready, 1 five-cycle hold at slot 7, 2 random ready
    task automatic run_frame(input int in_mode, input int out_mode, input bit pulse);
        int  cyc;
        int  k_in;
        int  k_out;
        int  hold;
        bit  acc_in;
        bit  acc_out;
        bit  seen_done;
        runs_cnt     = 0;
        done_cnt     = 0;
        ready_cycles = 0;
        k_in = 0; k_out = 0; hold = 0; cyc = 0; seen_done = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = gen(in_mode, 0);
        out_ready = 1'b1;
        while (!seen_done && cyc < 5000) begin
            @(negedge clk);
            acc_in    = in_valid && in_ready;
            acc_out   = out_valid && out_ready;
            seen_done = done;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (acc_in) begin
                k_in++;
                in_data = gen(in_mode, k_in);
                if (pulse && (k_in % N) == 10) start = 1'b1;
            end
            case (in_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ~in_valid;
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            if (acc_out) k_out++;
            case (out_mode)
                1: begin
                    if (acc_out && (k_out % N) == 7) hold = 5;
                    if (hold > 0) begin
                        out_ready = 1'b0;
                        hold--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                2:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
        end
        check(seen_done, "frame_timeout", cyc, 5000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic mid_run_reset();
        int low;
        int cyc;
        low = 0; cyc = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        @(posedge clk); #1;
        start = 1'b0;
        while (low < 4 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (!fft_rst) low++;
        end
        check(low == 4, "reach_wait3", low, 4);
        reset = 1'b0;
        #1;
        check(dbg_state == 2'd0, "abort_idle", dbg_state, 0);
        check(fft_rst == 1'b1, "abort_fft_rst", fft_rst, 1);
        check(out_valid == 1'b0, "abort_out_valid", out_valid, 0);
        check(col_idx == 5'd0, "abort_col_idx", col_idx, 0);
        check(busy == 1'b0, "abort_busy", busy, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check(out_valid == 1'b0, "no_partial_output", out_valid, 0);
            check(busy == 1'b0, "stay_idle", busy, 0);
        end
    endtask

    // ---------------- frame table ----------------
    typedef struct {
        int in_mode;
        int out_mode;
        bit pulse;
        int exp_ready;   // expected in_ready cycles per frame, -1 when stalls vary it
        int exp_runs;
        int exp_dones;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{in_mode: 0, out_mode: 0, pulse: 0, exp_ready: N*NUM_COLS, exp_runs: NUM_COLS, exp_dones: 1};
        tbl[1] = '{in_mode: 1, out_mode: 0, pulse: 0, exp_ready: -1,         exp_runs: NUM_COLS, exp_dones: 1};
        tbl[2] = '{in_mode: 2, out_mode: 1, pulse: 0, exp_ready: -1,         exp_runs: NUM_COLS, exp_dones: 1};
        tbl[3] = '{in_mode: 2, out_mode: 2, pulse: 1, exp_ready: -1,         exp_runs: NUM_COLS, exp_dones: 1};

        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        check(out_data == '0, "rst_out_data", out_data, 0);
        check(fft_in == '0, "rst_fft_in", {63'd0, |fft_in}, 0);
        check(fft_rst == 1'b1, "rst_fft_rst", fft_rst, 1);
        check(col_idx == 5'd0, "rst_col_idx", col_idx, 0);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(done == 1'b0, "rst_done", done, 0);
        check(dbg_state == 2'd0, "rst_state", dbg_state, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            if (i == 2) mid_run_reset();
            run_frame(tbl[i].in_mode, tbl[i].out_mode, tbl[i].pulse);
            check(runs_cnt == tbl[i].exp_runs, "run_windows", runs_cnt, tbl[i].exp_runs);
            check(done_cnt == tbl[i].exp_dones, "done_count", done_cnt, tbl[i].exp_dones);
            check(exp_q.size() == 0, "all_beats_out", exp_q.size(), 0);
            check(busy == 1'b0, "idle_after_frame", busy, 0);
            if (tbl[i].exp_ready >= 0)
                check(ready_cycles == tbl[i].exp_ready, "in_ready_cycles",
                      ready_cycles, tbl[i].exp_ready);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
